// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV32I immediate generator for the decode stage.
// Decodes one instruction per cycle into a format code and an XLEN-wide
// immediate, buffered behind a two-entry (main + skid) output stage so the
// input ready never depends combinationally on out_ready.
// Optional feature macro: IMM_GEN_CSR_EN (Zicsr-aware SYSTEM decode).
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; a producer holding valid keeps its payload stable until then,
// and out_* stay stable while out_valid && !out_ready.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] illegal_count
);

    typedef enum logic [2:0] {
        FMT_NONE    = 3'd0,
        FMT_I       = 3'd1,
        FMT_S       = 3'd2,
        FMT_B       = 3'd3,
        FMT_U       = 3'd4,
        FMT_J       = 3'd5,
        FMT_Z       = 3'd6,
        FMT_ILLEGAL = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        fmt_e             fmt;
        logic [TAG_W-1:0] tag;
    } entry_t;

    fmt_e        dec_fmt;
    logic [31:0] imm32;
    entry_t      dec_entry;
    entry_t      main_q;
    entry_t      skid_q;
    logic        main_valid;
    logic        skid_valid;
    logic [CNT_W-1:0] cnt_q;
    logic        accept;
    logic        drain;

    // Classify the incoming opcode and build its 32-bit immediate.
    always_comb begin
        dec_fmt = FMT_ILLEGAL;
        imm32   = '0;
        case (in_instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111: begin
                dec_fmt = FMT_I;
                imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FMT_U;
                imm32   = {in_instr[31:12], 12'b0};
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
            end
            7'b0110011: begin
                dec_fmt = FMT_NONE;
                imm32   = '0;
            end
            7'b1110011: begin
`ifdef IMM_GEN_CSR_EN
                case (in_instr[14:12])
                    3'b101, 3'b110, 3'b111: begin
                        dec_fmt = FMT_Z;
                        imm32   = {27'b0, in_instr[19:15]};
                    end
                    3'b001, 3'b010, 3'b011: begin
                        dec_fmt = FMT_I;
                        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
                    end
                    3'b000: begin
                        dec_fmt = FMT_NONE;
                        imm32   = '0;
                    end
                    default: begin
                        dec_fmt = FMT_ILLEGAL;
                        imm32   = '0;
                    end
                endcase
`else
                dec_fmt = FMT_I;
                imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
`endif
            end
            default: begin
                dec_fmt = FMT_ILLEGAL;
                imm32   = '0;
            end
        endcase
    end

    // Widen to XLEN (Z immediates have bit 31 clear, so this also zero-extends them).
    always_comb begin
        dec_entry.imm = XLEN'($signed(imm32));
        dec_entry.fmt = dec_fmt;
        dec_entry.tag = in_tag;
    end

    assign accept = in_valid && in_ready;
    assign drain  = main_valid && out_ready;

    // Main/skid buffer: new results go to main when it is free or draining,
    // otherwise to skid; skid refills main when main drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (drain) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_q     <= dec_entry;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (!main_valid) begin
            if (accept) begin
                main_q     <= dec_entry;
                main_valid <= 1'b1;
            end
        end else if (accept) begin
            skid_q     <= dec_entry;
            skid_valid <= 1'b1;
        end
    end

    // Saturating count of ILLEGAL instructions accepted (flush does not clear it).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept && dec_fmt == FMT_ILLEGAL && cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign in_ready      = !skid_valid;
    assign out_valid     = main_valid;
    assign out_imm       = main_q.imm;
    assign out_fmt       = main_q.fmt;
    assign out_tag       = main_q.tag;
    assign illegal_count = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: drives an XLEN=32/CNT_W=16 instance and an
// XLEN=64/CNT_W=2 instance from the same stimulus and compares both against
// an arithmetic decode model plus a depth-2 FIFO model of the output buffer.
module tb_imm_gen_pipe;

    localparam int EW = 3 + 64 + 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        in_ready_a, out_valid_a;
    logic [31:0] out_imm_a;
    logic [2:0]  out_fmt_a;
    logic [31:0] out_tag_a;
    logic [15:0] cnt_out_a;

    logic        in_ready_b, out_valid_b;
    logic [63:0] out_imm_b;
    logic [2:0]  out_fmt_b;
    logic [31:0] out_tag_b;
    logic [1:0]  cnt_out_b;

    // Clock
    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_imm(out_imm_a),
        .out_fmt(out_fmt_a), .out_tag(out_tag_a), .illegal_count(cnt_out_a)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_imm(out_imm_b),
        .out_fmt(out_fmt_b), .out_tag(out_tag_b), .illegal_count(cnt_out_b)
    );

    // Scoreboard state: expected queue holds {fmt, imm64, tag}
    logic [EW-1:0] exp_q[$];
    int cnt_a;
    int cnt_b;
    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [2:0]  fmt;
        logic [63:0] imm;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Reference decode: immediates built arithmetically from a 64-bit signed view.
    task automatic ref_dec(input logic [31:0] i, output logic [2:0] f, output logic [63:0] imm);
        longint s;
        longint r;
        s = longint'(signed'(i));
        r = 0;
        f = 3'd7;
        case (i[6:0])
            7'h13, 7'h03, 7'h67, 7'h0F: begin f = 3'd1; r = s >>> 20; end
            7'h23: begin f = 3'd2; r = (s >>> 25) * 32 + longint'(i[11:7]); end
            7'h63: begin
                f = 3'd3;
                r = (s >>> 31) * 4096 + longint'(i[7]) * 2048
                  + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
            end
            7'h37, 7'h17: begin f = 3'd4; r = (s >>> 12) * 4096; end
            7'h6F: begin
                f = 3'd5;
                r = (s >>> 31) * 1048576 + longint'(i[19:12]) * 4096
                  + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
            end
            7'h33: begin f = 3'd0; r = 0; end
            7'h73: begin
`ifdef IMM_GEN_CSR_EN
                case (i[14:12])
                    3'd5, 3'd6, 3'd7: begin f = 3'd6; r = longint'(i[19:15]); end
                    3'd1, 3'd2, 3'd3: begin f = 3'd1; r = s >>> 20; end
                    3'd0: begin f = 3'd0; r = 0; end
                    default: begin f = 3'd7; r = 0; end
                endcase
`else
                f = 3'd1; r = s >>> 20;
`endif
            end
            default: begin f = 3'd7; r = 0; end
        endcase
        imm = 64'(r);
    endtask

    task automatic check_all();
        logic [EW-1:0] h;
        chk("out_valid32", 64'(out_valid_a), 64'(exp_q.size() > 0));
        chk("out_valid64", 64'(out_valid_b), 64'(exp_q.size() > 0));
        chk("in_ready32", 64'(in_ready_a), 64'(exp_q.size() < 2));
        chk("in_ready64", 64'(in_ready_b), 64'(exp_q.size() < 2));
        if (exp_q.size() > 0) begin
            h = exp_q[0];
            chk("fmt32", 64'(out_fmt_a), 64'(h[98:96]));
            chk("fmt64", 64'(out_fmt_b), 64'(h[98:96]));
            chk("imm32", 64'(out_imm_a), 64'(h[63:32]));
            chk("imm64", out_imm_b, h[95:32]);
            chk("tag32", 64'(out_tag_a), 64'(h[31:0]));
            chk("tag64", 64'(out_tag_b), 64'(h[31:0]));
        end
        chk("count16", 64'(cnt_out_a), 64'(cnt_a));
        chk("count2", 64'(cnt_out_b), 64'(cnt_b));
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_valid"}, 64'(out_valid_a | out_valid_b), 64'd0);
        chk({nm, "_ready"}, 64'(in_ready_a & in_ready_b), 64'd1);
        chk({nm, "_imm"}, out_imm_b | 64'(out_imm_a), 64'd0);
        chk({nm, "_fmt"}, 64'(out_fmt_a | out_fmt_b), 64'd0);
        chk({nm, "_tag"}, 64'(out_tag_a | out_tag_b), 64'd0);
        chk({nm, "_count"}, 64'(cnt_out_a) | 64'(cnt_out_b), 64'd0);
    endtask

    // One clock: advance the model with the inputs that the edge will see, then check.
    task automatic cycle();
        logic [2:0]  f;
        logic [63:0] imm;
        bit          acc;
        ref_dec(in_instr, f, imm);
        acc = in_valid && (exp_q.size() < 2);
        if (acc && f == 3'd7) begin
            if (cnt_a < 65535) cnt_a++;
            if (cnt_b < 3) cnt_b++;
        end
        if (flush) exp_q.delete();
        else begin
            if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
            if (acc) exp_q.push_back({f, imm, in_tag});
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] tg, input logic rdy);
        in_valid  = v;
        in_instr  = ins;
        in_tag    = tg;
        out_ready = rdy;
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        exp_q.delete();
        cnt_a = 0;
        cnt_b = 0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [6:0]  ops[10] = '{7'h13, 7'h03, 7'h67, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h33, 7'h73};
        logic [31:0] r;
        int          p;
        r = $urandom;
        p = $urandom_range(0, 11);
        if (p < 10) r[6:0] = ops[p];
        return r;
    endfunction

    initial begin
        // Directed decode table
        tbl[0]  = '{32'hFFF00093, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[1]  = '{32'hFE112E23, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC};
        tbl[2]  = '{32'hFE000CE3, 3'd3, 64'hFFFF_FFFF_FFFF_FFF8};
        tbl[3]  = '{32'h123450B7, 3'd4, 64'h0000_0000_1234_5000};
        tbl[4]  = '{32'h0010006F, 3'd5, 64'h0000_0000_0000_0800};
        tbl[5]  = '{32'h00000000, 3'd7, 64'h0};
        tbl[6]  = '{32'h00000033, 3'd0, 64'h0};
        tbl[7]  = '{32'h80000037, 3'd4, 64'hFFFF_FFFF_8000_0000};
        tbl[8]  = '{32'h7FF00013, 3'd1, 64'h0000_0000_0000_07FF};
`ifdef IMM_GEN_CSR_EN
        tbl[9]  = '{32'h3002D073, 3'd6, 64'h5};
`else
        tbl[9]  = '{32'h3002D073, 3'd1, 64'h300};
`endif
        tbl[10] = '{32'h80000017, 3'd4, 64'hFFFF_FFFF_8000_0000};

        // Reset
        rst_n = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        cnt_a = 0;
        cnt_b = 0;
        #1 chk_reset_vals("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // Streaming table, out_ready high: each result appears the next cycle
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, tbl[i].instr, 32'h100 + i, 1'b1);
            cycle();
            chk($sformatf("tbl%0d_fmt", i), 64'(out_fmt_a), 64'(tbl[i].fmt));
            chk($sformatf("tbl%0d_imm32", i), 64'(out_imm_a), 64'(tbl[i].imm[31:0]));
            chk($sformatf("tbl%0d_imm64", i), out_imm_b, tbl[i].imm);
            chk($sformatf("tbl%0d_tag", i), 64'(out_tag_a), 64'(32'h100 + i));
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        cycle();

        // Backpressure: three offered with out_ready low, only two taken
        drive(1'b1, 32'hFFF00093, 32'hA1, 1'b0);
        cycle();
        chk("bp_ready_after_1", 64'(in_ready_a), 64'd1);
        drive(1'b1, 32'hFE112E23, 32'hA2, 1'b0);
        cycle();
        chk("bp_ready_after_2", 64'(in_ready_a), 64'd0);
        drive(1'b1, 32'hFE000CE3, 32'hA3, 1'b0);
        cycle();
        chk("bp_hold_tag", 64'(out_tag_a), 64'hA1);
        chk("bp_hold_imm", 64'(out_imm_a), 64'hFFFF_FFFF);
        out_ready = 1'b1;
        cycle();
        chk("bp_rel_tag", 64'(out_tag_a), 64'hA2);
        chk("bp_rel_ready", 64'(in_ready_a), 64'd1);
        cycle();
        chk("bp_third_tag", 64'(out_tag_a), 64'hA3);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        for (int k = 0; k < 8 && exp_q.size() > 0; k++) cycle();
        cycle();
        chk("bp_drained", 64'(out_valid_a), 64'd0);

        // Flush with both entries full and a new instruction offered
        drive(1'b1, 32'h00000013, 32'hB1, 1'b0);
        cycle();
        drive(1'b1, 32'h00000013, 32'hB2, 1'b0);
        cycle();
        drive(1'b0, 32'h00000013, 32'hB3, 1'b0);
        cycle();
        flush = 1'b1;
        drive(1'b1, 32'h00000000, 32'hDEAD, 1'b0);
        cycle();
        chk("flush_valid", 64'(out_valid_a), 64'd0);
        chk("flush_ready", 64'(in_ready_a), 64'd1);
        chk("flush_cnt", 64'(cnt_out_a), 64'(cnt_a));
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        for (int k = 0; k < 3; k++) cycle();

        // Asynchronous reset mid-stream
        drive(1'b1, 32'hFFF00093, 32'hC1, 1'b0);
        cycle();
        drive(1'b1, 32'h0010006F, 32'hC2, 1'b0);
        cycle();
        async_reset();
        cycle();

        // Saturation: five illegals, 2-bit counter stops at 3
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h0, 32'hD0 + k, 1'b1);
            cycle();
        end
        chk("sat_count16", 64'(cnt_out_a), 64'd5);
        chk("sat_count2", 64'(cnt_out_b), 64'd3);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        cycle();

        // Randomized traffic with backpressure and occasional flush
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 9) < 7), rnd_instr(), $urandom, ($urandom_range(0, 9) < 6));
            flush = ($urandom_range(0, 49) == 0);
            cycle();
        end
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        for (int k = 0; k < 4; k++) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. It accepts one RV32I instruction per cycle over a valid/ready handshake and classifies its format. It produces the XLEN-wide extended immediate one cycle later, through a 2-entry skid buffer, so the execute stage can stall without a combinational ready path. It also flags unsupported opcodes and keeps a saturating count of them.

## Interface
- XLEN, 32: immediate output width; 32 or 64; sign extension fills bits XLEN-1 down to the field MSB.
- TAG_W, 32: width of the opaque sideband tag (PC or ROB id) carried alongside the instruction.
- CNT_W, 16: width of the illegal-instruction counter.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous; discards all buffered entries.
- in_valid  input  1  instruction present.
- in_ready  output  1  block can accept; registered, not a function of out_ready.
- in_instr  input  32  RV32I instruction word.
- in_tag  input  TAG_W  sideband, passed through unchanged.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts.
- out_imm  output  XLEN  extended immediate.
- out_fmt  output  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z, 7 ILLEGAL.
- out_tag  output  TAG_W  tag of the instruction on out_imm.
- illegal_count  output  CNT_W  saturating count of ILLEGAL results accepted at the input.

## Operation
- Decode on opcode inst[6:0]:
  - 0010011, 0000011, 1100111, 0001111 → I, imm = sext(inst[31:20]).
  - 0100011 → S, sext({inst[31:25], inst[11:7]}).
  - 1100011 → B, sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - 0110111, 0010111 → U, sext({inst[31:12], 12'b0}); sign extended for XLEN=64.
  - 1101111 → J, sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - 0110011 → NONE, imm 0.
  - 1110011 → see Configuration.
  - Any other opcode → ILLEGAL, imm 0.
- Storage: output register (main) plus one skid register.
  - in_ready = !skid_valid.
  - Accept when in_valid && in_ready.
  - If main is empty, or is being drained this cycle (out_valid && out_ready), the accepted result loads main.
  - Otherwise the accepted result loads skid.
  - When main drains and skid is full, skid moves to main.
- Order is strictly FIFO. No entry is ever dropped or duplicated except by flush.
- flush clears main and skid valids on the next edge and overrides a simultaneous accept. illegal_count still counts an ILLEGAL accepted in the flush cycle.
- illegal_count increments by 1 per accepted ILLEGAL and holds at 2^CNT_W−1. It is cleared only by reset.

## Timing
- Reset values: out_valid 0, in_ready 1, out_imm 0, out_fmt 0, out_tag 0, illegal_count 0. Internal skid is empty.
- Latency: accepted instruction is on the outputs the next cycle if main was empty or draining.
- Throughput: 1 per cycle with out_ready held high.
- Backpressure:
  - Outputs hold stable while out_valid && !out_ready.
  - At most two results are buffered.
  - in_ready drops the cycle after the skid fills and rises the cycle after it empties.
- Simultaneous accept and drain with skid empty: the new result replaces main and in_ready stays 1.
- Reset asserted mid-operation: all state returns to reset values immediately. In-flight entries are lost.

## Configuration
- IMM_GEN_CSR_EN defined, SYSTEM opcode (1110011):
  - funct3 101/110/111 → Z, imm = zero-extended inst[19:15].
  - funct3 001/010/011 → I (CSR address).
  - funct3 000 → NONE.
  - funct3 100 → ILLEGAL.
- Not defined: every SYSTEM instruction → I, sext(inst[31:20]), and Z is never produced.

## Test plan
- Streaming, out_ready=1: 0xFFF00093, 0xFE112E23, 0xFE000CE3 → consecutive cycles give I/0xFFFFFFFF, S/0xFFFFFFFC, B/0xFFFFFFF8 with tags preserved.
- U and J decode:
  - XLEN=64: 0x123450B7 → U/0x0000000012345000.
  - XLEN=32: 0x0010006F → J/0x00000800.
- Backpressure: out_ready=0 while 3 instructions are offered → two accepted, in_ready=0 from the cycle after the second. Release out_ready → outputs in order with no loss; in_ready returns to 1 one cycle after the skid empties.
- Illegal: 0x00000000 → fmt 7, imm 0, illegal_count 0→1. With CNT_W=2, 5 illegals → count holds at 3.
- CSR: 0x3002D073 → Z/0x00000005 with IMM_GEN_CSR_EN, I/0x00000300 without it.
- Flush with both entries full and in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed instruction never appears. Asynchronous rst_n pulse mid-stream → all outputs return to reset values immediately.
